rocketcpu_irqc: RTL and testbench

//  Parametrised Wishbone interrupt controller; successor to the 3-line fixed-level IRQ block.

---
 rtl/rocketcpu_irqc.sv | 94 +++++++++
 tb/tb_rocketcpu_irqc.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rocketcpu_irqc.sv
// Wishbone interrupt controller: per-channel synchronisers, edge/level mode, polarity,
// W1C pending with software set, and a lowest-index-wins ACTIVE register.
module rocketcpu_irqc #(
    parameter int          NIRQ     = 8,
    parameter logic [31:0] BASE_ADR = 32'h0900_0000
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rst,
    input  logic [31:0]     i_wb_adr,
    input  logic [31:0]     i_wb_dat,
    input  logic            i_wb_we,
    input  logic            i_wb_cyc,
    output logic [31:0]     o_wb_rdt,
    output logic            o_wb_ack,
    input  logic [NIRQ-1:0] i_irq,
    output logic            o_irq
);

    logic [NIRQ-1:0] sync1_reg, sync2_reg, prev_reg;
    logic [NIRQ-1:0] pending_reg, enable_reg, mode_reg, polarity_reg;
    logic [NIRQ-1:0] pending_next, line_s, set_bits, clr_bits, wdat, pe;
    logic [2:0]      off;
    logic            access, hit, wr;
    logic [4:0]      active_idx;
    logic [31:0]     rd_word;
    logic            unused_bits;

    assign off    = i_wb_adr[4:2];
    assign access = i_wb_cyc & ~o_wb_ack;
    assign hit    = (i_wb_adr[31:5] == BASE_ADR[31:5]);
    assign wr     = access & hit & i_wb_we;
    assign wdat   = i_wb_dat[NIRQ-1:0];

    assign unused_bits = ^{i_wb_adr[1:0], i_wb_dat};

    assign line_s   = sync2_reg ^ polarity_reg;
    assign set_bits = (wr && off == 3'd5) ? wdat : '0;
    assign clr_bits = (wr && off == 3'd0) ? wdat : '0;
    assign pe       = pending_reg & enable_reg;

    // Edge channels: a new edge or SET wins over a coinciding W1C.
    // Level channels simply follow the line, so W1C cannot stick while it is asserted.
    assign pending_next = (mode_reg & ((pending_reg & ~clr_bits) | (line_s & ~prev_reg) | set_bits))
                        | (~mode_reg & (line_s | set_bits));

    // Descending scan so the lowest pending index is the last one assigned.
    always_comb begin
        active_idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (pe[i]) active_idx = 5'(i);
        end
    end

    always_comb begin
        rd_word = '0;
        if (hit) begin
            case (off)
                3'd0: rd_word[NIRQ-1:0] = pending_reg;
                3'd1: rd_word[NIRQ-1:0] = enable_reg;
                3'd2: rd_word[NIRQ-1:0] = mode_reg;
                3'd3: rd_word[NIRQ-1:0] = polarity_reg;
                3'd4: rd_word = {|pe, 26'd0, active_idx};
                default: rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            prev_reg     <= '0;
            pending_reg  <= '0;
            enable_reg   <= '0;
            mode_reg     <= '0;
            polarity_reg <= '0;
            o_wb_rdt     <= '0;
            o_wb_ack     <= 1'b0;
            o_irq        <= 1'b0;
        end else begin
            sync1_reg   <= i_irq;
            sync2_reg   <= sync1_reg;
            prev_reg    <= line_s;
            pending_reg <= pending_next;
            o_irq       <= |pe;
            o_wb_ack    <= access;
            if (access) o_wb_rdt <= rd_word;
            if (wr && off == 3'd1) enable_reg   <= wdat;
            if (wr && off == 3'd2) mode_reg     <= wdat;
            if (wr && off == 3'd3) polarity_reg <= wdat;
        end
    end

endmodule

// File: tb/tb_rocketcpu_irqc.sv
// Directed bench for rocketcpu_irqc: bus handshake, edge/level pending, masking,
// ACTIVE priority, set-vs-clear collision, width masking and async reset.
module tb_rocketcpu_irqc;

    localparam logic [31:0] BASE = 32'h0900_0000;
    localparam logic [31:0] R_PEND = BASE + 32'h00;
    localparam logic [31:0] R_EN   = BASE + 32'h04;
    localparam logic [31:0] R_MODE = BASE + 32'h08;
    localparam logic [31:0] R_POL  = BASE + 32'h0C;
    localparam logic [31:0] R_ACT  = BASE + 32'h10;
    localparam logic [31:0] R_SET  = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, dat, rdt;
    logic        we, cyc, ack, irq_out;
    logic [7:0]  irq;

    int checks   = 0;
    int failures = 0;

    rocketcpu_irqc #(.NIRQ(8), .BASE_ADR(BASE)) dut (
        .i_wb_clk(clk),
        .i_wb_rst(rst),
        .i_wb_adr(adr),
        .i_wb_dat(dat),
        .i_wb_we (we),
        .i_wb_cyc(cyc),
        .o_wb_rdt(rdt),
        .o_wb_ack(ack),
        .i_irq   (irq),
        .o_irq   (irq_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the ack has dropped.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        check("ack_idle", {31'd0, ack}, 32'd0);
        cyc = 1'b1; we = w; adr = a; dat = d;
        @(negedge clk);
        check("ack_one_cycle", {31'd0, ack}, 32'd1);
        r = rdt;
        $display("bus %s adr=%h wdat=%h rdat=%h", w ? "WR" : "RD", a, d, r);
        cyc = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, a, d, r);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, a, 32'd0, r);
        check(tag, r, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, irq_out}, {31'd0, exp});
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; we = 1'b0; adr = '0; dat = '0; irq = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdt", rdt, 32'd0);
        chk_irq("rst_irq", 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Every offset reads zero after reset
        for (int i = 0; i < 8; i++) rd("rst_read", BASE + 32'(4 * i), 32'd0);
        chk_irq("idle_irq", 1'b0);

        // Edge channel 2: 4-cycle latency, ACTIVE, W1C
        wr(R_EN, 32'h04);
        wr(R_MODE, 32'h04);
        irq = 8'h04;
        @(negedge clk);
        irq = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk_irq("edge_lat3", 1'b0);
        @(negedge clk);
        chk_irq("edge_lat4", 1'b1);
        rd("edge_pend", R_PEND, 32'h04);
        rd("edge_active", R_ACT, 32'h8000_0002);
        wr(R_PEND, 32'h04);
        chk_irq("w1c_irq", 1'b0);
        rd("w1c_pend", R_PEND, 32'h00);

        // Level channel 5, active-low, line held low
        wr(R_POL, 32'h20);
        rd("lvl_pend", R_PEND, 32'h20);
        wr(R_PEND, 32'h20);
        rd("lvl_w1c", R_PEND, 32'h20);
        wr(R_EN, 32'h24);
        chk_irq("lvl_irq", 1'b1);
        irq = 8'h20;
        repeat (3) @(negedge clk);
        chk_irq("lvl_rel3", 1'b1);
        @(negedge clk);
        chk_irq("lvl_rel4", 1'b0);
        rd("lvl_clear", R_PEND, 32'h00);

        // Masked channel 1 still latches
        wr(R_EN, 32'h00);
        wr(R_MODE, 32'h06);
        irq = 8'h22;
        @(negedge clk);
        irq = 8'h20;
        repeat (3) @(negedge clk);
        chk_irq("mask_irq", 1'b0);
        rd("mask_pend", R_PEND, 32'h02);
        wr(R_EN, 32'h02);
        @(negedge clk);
        chk_irq("unmask_irq", 1'b1);

        // ACTIVE priority and SET register
        wr(R_PEND, 32'h02);
        wr(R_MODE, 32'h97);
        wr(R_EN, 32'hF0);
        wr(R_SET, 32'h90);
        rd("set_pend", R_PEND, 32'h90);
        rd("prio_active", R_ACT, 32'h8000_0004);
        chk_irq("prio_irq", 1'b1);
        rd("set_reads0", R_SET, 32'h0);
        wr(R_EN, 32'hF1);
        wr(R_SET, 32'h01);
        rd("prio_active0", R_ACT, 32'h8000_0000);

        // Edge coinciding with W1C of the same bit: set wins
        wr(R_PEND, 32'hFF);
        rd("clr_all", R_PEND, 32'h00);
        irq = 8'h21;
        @(negedge clk);
        @(negedge clk);
        wr(R_PEND, 32'h01);
        rd("set_beats_clr", R_PEND, 32'h01);

        // Width masking and address decode
        wr(R_EN, 32'hFFFF_FFFF);
        rd("en_width", R_EN, 32'h0000_00FF);
        wr(32'h0A00_0004, 32'h0);
        rd("miss_wr_ignored", R_EN, 32'h0000_00FF);
        rd("miss_rd", 32'h0A00_0000, 32'h0);
        rd("unmapped_rd", BASE + 32'h18, 32'h0);

        // Reset in the middle of an ack
        cyc = 1'b1; we = 1'b0; adr = R_EN;
        @(posedge clk);
        #1;
        check("mid_ack", {31'd0, ack}, 32'd1);
        check("mid_rdt", rdt, 32'h0000_00FF);
        rst = 1'b1; irq = 8'h00;
        #1;
        check("rst_async_ack", {31'd0, ack}, 32'd0);
        check("rst_async_rdt", rdt, 32'd0);
        chk_irq("rst_async_irq", 1'b0);
        @(negedge clk);
        cyc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd("post_rst_en", R_EN, 32'h0);
        rd("post_rst_pend", R_PEND, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
